fetch_prefetch: RTL

Parametrised instruction-fetch front end that replaces the single-entry fetch path. It keeps up to MaxOutstanding instruction-memory reads in flight and buffers returned instructions in a Depth-entry queue. On a control hazard it redirects the PC and silently discards responses to requests issued before the redirect. It sits between the instruction-memory port and the IF->ID pipeline register, which consumes inst_* with a valid/ready handshake.

---
 rtl/fetch_prefetch.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end with several memory reads in flight and a
// small instruction queue between the memory port and the IF->ID register.
// A redirect flushes the queue, retargets the PC and drops the responses to
// requests issued before it.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   control_hazard_i    redirect request; pc_target_i is the new PC
//   mem_valid_o/ready_i request handshake, mem_addr_o = fetch PC
//   mem_rvalid_i/rdata  in-order read responses
//   inst_valid_o/ready_i queue head handshake; inst_pc_o/inst_data_o payload
module fetch_prefetch #(
  parameter int unsigned   Xlen           = 32,
  parameter int unsigned   Ilen           = 32,
  parameter int unsigned   Depth          = 4,
  parameter int unsigned   MaxOutstanding = 2,
  parameter logic [Xlen-1:0] ResetPc      = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            control_hazard_i,
  input  logic [Xlen-1:0] pc_target_i,
  input  logic            mem_ready_i,
  output logic            mem_valid_o,
  output logic [Xlen-1:0] mem_addr_o,
  input  logic [Xlen-1:0] mem_rdata_i,
  input  logic            mem_rvalid_i,
  input  logic            inst_ready_i,
  output logic            inst_valid_o,
  output logic [Xlen-1:0] inst_pc_o,
  output logic [Ilen-1:0] inst_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam int unsigned SumW = $clog2(Depth + MaxOutstanding + 1);

  logic [Xlen-1:0] fetch_pc_q, fetch_pc_d;
  logic [Xlen-1:0] resp_pc_q, resp_pc_d;
  logic [OutW-1:0] out_q, out_d;
  logic [OutW-1:0] stale_q, stale_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic            started_q;

  logic [Xlen-1:0] pc_mem   [Depth];
  logic [Ilen-1:0] data_mem [Depth];

  logic [Xlen-1:0] target_al;
  logic [OutW-1:0] live;
  logic            credit_ok;
  logic            accept;
  logic            resp;
  logic            push;
  logic            pop;
  logic [31:0]     word;

  assign target_al = pc_target_i & ~Xlen'(3);
  assign live      = out_q - stale_q;
  // Every live response must have a queue slot reserved before it is requested.
  assign credit_ok = (SumW'(count_q) + SumW'(live)) < SumW'(Depth);

  assign mem_valid_o = rst_ni && started_q && !control_hazard_i &&
                       (out_q < OutW'(MaxOutstanding)) && credit_ok;
  assign mem_addr_o  = fetch_pc_q;

  assign accept = mem_valid_o && mem_ready_i;
  // Responses with nothing outstanding are spurious and ignored.
  assign resp   = mem_rvalid_i && (out_q != '0);
  assign push   = resp && (stale_q == '0) && !control_hazard_i;
  assign pop    = inst_valid_o && inst_ready_i && !control_hazard_i;

  // On a 64-bit port the instruction sits in the half addressed by PC bit 2.
  if (Xlen == 64) begin : g_x64
    assign word = resp_pc_q[2] ? mem_rdata_i[Xlen-1:32] : mem_rdata_i[31:0];
  end else begin : g_x32
    assign word = mem_rdata_i[31:0];
  end

  assign inst_valid_o = (count_q != '0);
  assign inst_pc_o    = pc_mem[rd_ptr_q];
  assign inst_data_o  = data_mem[rd_ptr_q];

  // Next-state for PCs, counters and queue pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + OutW'(accept) - OutW'(resp);
    stale_d    = stale_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (control_hazard_i) begin
      fetch_pc_d = target_al;
      resp_pc_d  = target_al;
      // Everything still outstanding after this cycle's response is stale.
      stale_d    = out_q - OutW'(resp);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + Xlen'(4);
      if (push) begin
        resp_pc_d = resp_pc_q + Xlen'(4);
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (resp && (stale_q != '0)) stale_d = stale_q - OutW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= ResetPc;
      resp_pc_q  <= ResetPc;
      out_q      <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      started_q  <= 1'b1;
    end
  end

  // Queue storage; validity is tracked by count_q so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      data_mem[wr_ptr_q] <= Ilen'(word);
    end
  end

endmodule
